// File: rtl/imm_extend_stage_pkg.sv
// Shared definitions for the ID->EX immediate-extension stage.
//   EXT_*   : 2-bit extension-mode codes, also used by the instruction decoder.
//   occ_t   : occupancy of the output register + skid buffer pair.
package imm_extend_stage_pkg;

    localparam logic [1:0] EXT_SIGN   = 2'b00;
    localparam logic [1:0] EXT_ZERO   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate-extension mode mux.
// Ports:
//   imm  in  IN_W   raw immediate field
//   mode in  2      EXT_SIGN / EXT_ZERO / EXT_UPPER / EXT_BRANCH
//   ext  out OUT_W  extended immediate
module imm_ext_core #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);
    import imm_extend_stage_pkg::*;

    localparam int UP_SHIFT = OUT_W - IN_W;

    if (OUT_W < IN_W + BR_SHIFT) begin : g_width_check
        $error("imm_ext_core: OUT_W must be >= IN_W + BR_SHIFT");
    end

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;

    // A size cast of a signed operand sign-extends, which also covers OUT_W == IN_W
    // where a zero-count replication would be illegal.
    assign sign_ext = OUT_W'($signed(imm));
    assign zero_ext = OUT_W'(imm);

    always_comb begin
        unique case (mode)
            EXT_SIGN:  ext = sign_ext;
            EXT_ZERO:  ext = zero_ext;
            EXT_UPPER: ext = zero_ext << UP_SHIFT;
            default:   ext = sign_ext << BR_SHIFT;  // EXT_BRANCH, truncated to OUT_W
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage between ID and EX.
// An output register plus a one-entry skid buffer carry the extended immediate
// downstream under a valid/ready handshake; flush drops everything held.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   flush      in   1      drop held and incoming entries
//   in_valid   in   1      immediate/mode presented
//   in_ready   out  1      stage can accept (registered, no path from out_ready)
//   in_imm     in   IN_W   raw immediate field
//   in_mode    in   2      extension mode
//   out_valid  out  1      out_data valid
//   out_ready  in   1      EX accepts
//   out_data   out  OUT_W  extended immediate
//   out_neg    out  1      out_data[OUT_W-1], registered with the data
module imm_extend_stage #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);
    import imm_extend_stage_pkg::*;

    occ_t             occ;
    occ_t             occ_next;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] skid_data;
    logic             skid_neg;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    imm_ext_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_core (
        .imm (in_imm),
        .mode(in_mode),
        .ext (ext)
    );

    // Both handshake outputs decode the occupancy register only.
    assign in_ready  = (occ != OCC_TWO);
    assign out_valid = (occ != OCC_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        occ_next      = occ;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (occ)
            OCC_EMPTY: begin
                if (in_xfer) begin
                    occ_next    = OCC_ONE;
                    load_out_in = 1'b1;
                end
            end
            OCC_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (in_xfer) begin
                    occ_next  = OCC_TWO;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    occ_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (out_xfer) begin
                    occ_next      = OCC_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: occ_next = OCC_EMPTY;
        endcase
        // Flush only clears occupancy; data registers keep their stale contents.
        if (flush) begin
            occ_next      = OCC_EMPTY;
            load_out_in   = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ      <= OCC_EMPTY;
            out_data <= '0;
            out_neg  <= 1'b0;
        end else begin
            occ <= occ_next;
            if (load_out_in) begin
                out_data <= ext;
                out_neg  <= ext[OUT_W-1];
            end else if (load_out_skid) begin
                out_data <= skid_data;
                out_neg  <= skid_neg;
            end
        end
    end

    // NOTE: skid payload has no reset; it is only ever read while occupancy says it is valid.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= ext;
            skid_neg  <= ext[OUT_W-1];
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
module tb_imm_extend_stage;
    import imm_extend_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        in_ready, out_valid, out_neg;
    logic [31:0] out_data;

    logic        s_flush, s_in_valid, s_out_ready;
    logic [11:0] s_in_imm;
    logic [1:0]  s_in_mode;
    logic        s_in_ready, s_out_valid, s_out_neg;
    logic [15:0] s_out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_extend_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
    );

    imm_extend_stage #(.IN_W(12), .OUT_W(16), .BR_SHIFT(0)) dut_s (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_neg(s_out_neg)
    );

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];
    vec_t s_vecs[3];
    logic [31:0] q[$];
    logic [15:0] got[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference extension from the arithmetic meaning of each mode.
    function automatic logic [63:0] ref_ext(input longint imm, input int mode,
                                            input int in_w, input int out_w, input int br);
        longint sval;
        longint res;
        longint mask;
        mask = (longint'(1) << out_w) - 1;
        sval = (imm >= (longint'(1) << (in_w - 1))) ? imm - (longint'(1) << in_w) : imm;
        case (mode)
            0:       res = sval;
            1:       res = imm;
            2:       res = imm * (longint'(1) << (out_w - in_w));
            default: res = sval * (longint'(1) << br);
        endcase
        return 64'(res & mask);
    endfunction

    initial begin
        logic [63:0] r;
        logic        acc;

        vecs[0] = '{16'h8001, EXT_SIGN,   32'hFFFF8001};
        vecs[1] = '{16'h8001, EXT_ZERO,   32'h00008001};
        vecs[2] = '{16'h1234, EXT_UPPER,  32'h12340000};
        vecs[3] = '{16'hFFFF, EXT_BRANCH, 32'hFFFFFFFC};
        // Upper-load puts the 12-bit immediate in the top 12 of 16 bits.
        s_vecs[0] = '{16'h0800, EXT_SIGN,   32'h0000F800};
        s_vecs[1] = '{16'h0800, EXT_BRANCH, 32'h0000F800};
        s_vecs[2] = '{16'h0ABC, EXT_UPPER,  32'h0000ABC0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_imm = 16'h5555;
        in_mode = EXT_SIGN; out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_imm = '0; s_in_mode = EXT_SIGN; s_out_ready = 1'b1;

        // Reset held three cycles with input offered.
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_neg", out_neg, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0; in_valid = 1'b0;
        step();
        check("rst_idle_out_valid", out_valid, 0);

        // Mode table, streamed back to back with out_ready high.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_imm = vecs[i].imm; in_mode = vecs[i].mode;
            step();
            check($sformatf("mode%0d_valid", i), out_valid, 1);
            check($sformatf("mode%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("mode%0d_neg", i), out_neg, vecs[i].exp[31]);
        end
        in_valid = 1'b0;
        step();
        check("mode_drain_valid", out_valid, 0);

        // Backpressure: A, B fill both slots, C is held off.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = EXT_SIGN; in_imm = 16'h0001;
        step();
        check("bp_a_in_ready", in_ready, 1);
        in_imm = 16'h0002;
        step();
        check("bp_b_in_ready", in_ready, 0);
        check("bp_b_out_data", out_data, 32'h1);
        in_imm = 16'h0003;
        step();
        check("bp_c_in_ready", in_ready, 0);
        check("bp_c_stable", out_data, 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic take_in;
            take_in = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_data[15:0]);
            step();
            if (take_in) in_valid = 1'b0;
        end
        check("bp_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++)
            check($sformatf("bp_order%0d", i), got[i], i + 1);

        // Flush with two entries held and D offered.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = EXT_ZERO; in_imm = 16'h00E0;
        step();
        in_imm = 16'h00F0;
        step();
        check("fl_two_in_ready", in_ready, 0);
        in_imm = 16'h00D0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_two_out_valid", out_valid, 0);
        check("fl_two_in_ready_back", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fl_two_no_d%0d", i), out_valid, 0);
        end
        // Flush with one entry held: the offered D is discarded, not accepted.
        out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0070;
        step();
        in_imm = 16'h00D0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_one_out_valid", out_valid, 0);
        step();
        check("fl_one_no_d", out_valid, 0);
        out_ready = 1'b1;

        // Parameter sweep on the 12/16/0 instance.
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1'b1; s_in_imm = s_vecs[i].imm[11:0]; s_in_mode = s_vecs[i].mode;
            step();
            check($sformatf("sw%0d_valid", i), s_out_valid, 1);
            check($sformatf("sw%0d_data", i), s_out_data, s_vecs[i].exp[15:0]);
            check($sformatf("sw%0d_neg", i), s_out_neg, s_vecs[i].exp[15]);
        end
        s_in_valid = 1'b0;

        // Random traffic against a queue scoreboard (main instance starts empty).
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            check("rnd_in_ready", in_ready, q.size() < 2);
            check("rnd_out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("rnd_out_data", out_data, q[0]);
                check("rnd_out_neg", out_neg, q[0][31]);
            end
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (acc) begin
                r = ref_ext(longint'(in_imm), int'(in_mode), 16, 32, 2);
                q.push_back(r[31:0]);
            end
            step();
        end
        flush = 1'b0;

        // Reset mid-stream with both slots full.
        out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h8888; in_mode = EXT_SIGN;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("mid_rst_no_output", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
